// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg
// Shared types for the chiplet switch.
//   OUTSTAGE_MAX_VCS : upper bound on virtual channels an outport stage may use
//   vc_id_t          : VC identifier carried inside a flit
//   flit_t           : link flit (head/tail markers, VC id, payload)
//   lock_state_e     : per-VC wormhole lock state used by switch_outport_stage
package chiplet_types_pkg;

  localparam int OUTSTAGE_MAX_VCS = 16;
  localparam int VC_ID_W          = $clog2(OUTSTAGE_MAX_VCS);
  localparam int FLIT_DATA_W      = 32;

  typedef logic [VC_ID_W-1:0] vc_id_t;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    vc_id_t                 vc;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic {
    LK_FREE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Index width that stays legal (>=1) for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/outport_credit_counter.sv
// outport_credit_counter
// Downstream credit tracker for one virtual channel.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_dec     : a flit was sent on this VC (only issued while o_avail)
//   i_inc     : downstream returned one slot
//   o_count   : current credit count, resets to BUFFER_SIZE
//   o_avail   : count is non-zero, VC may send
//   o_err     : sticky, a return arrived while already full with no send
module outport_credit_counter #(
  parameter int BUFFER_SIZE = 8,
  parameter int CRED_W      = $clog2(BUFFER_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dec,
  input  logic              i_inc,
  output logic [CRED_W-1:0] o_count,
  output logic              o_avail,
  output logic              o_err
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(BUFFER_SIZE);

  logic [CRED_W-1:0] r_count;
  logic              r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= FULL;
      r_err   <= 1'b0;
    end else begin
      case ({i_dec, i_inc})
        2'b10: if (r_count != '0) r_count <= r_count - CRED_W'(1);
        // Overflowing return is dropped but remembered.
        2'b01: if (r_count == FULL) r_err <= 1'b1;
               else                 r_count <= r_count + CRED_W'(1);
        default: ; // none, or send and return cancel out
      endcase
    end
  end

  assign o_count = r_count;
  assign o_avail = (r_count != '0);
  assign o_err   = r_err;

endmodule

// File: rtl/switch_outport_stage.sv
// switch_outport_stage
// Output-port stage: round-robin arbitration of NUM_IN input buffers onto one
// link, NUM_VCS downstream VCs with credit flow control and wormhole locks.
// Optional macro OUTSTAGE_LOCK_TIMEOUT_EN: per-VC idle counter that forcibly
// frees a lock whose owner has not sent for LOCK_TIMEOUT cycles.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/flit/vc/last : head-of-buffer flit per input and its output VC
//   in_pop         : one-hot combinational grant (flit consumed this cycle)
//   credit_return  : per-VC returned slot
//   out_valid/flit : registered flit toward the link (vc field = in_vc)
//   credits        : per-VC credit counts
//   credit_err     : sticky credit overflow
//   timeout_err    : sticky forced lock release (0 without the macro)
module switch_outport_stage
  import chiplet_types_pkg::*;
#(
  parameter int NUM_IN       = 8,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_SIZE  = 8,
  parameter int LOCK_TIMEOUT = 256,
  localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CRED_W      = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_IN-1:0]               in_valid,
  input  flit_t [NUM_IN-1:0]              in_flit,
  input  logic [NUM_IN-1:0][VC_W-1:0]     in_vc,
  input  logic [NUM_IN-1:0]               in_last,
  output logic [NUM_IN-1:0]               in_pop,
  input  logic [NUM_VCS-1:0]              credit_return,
  output logic                            out_valid,
  output flit_t                           out_flit,
  output logic [NUM_VCS-1:0][CRED_W-1:0]  credits,
  output logic                            credit_err,
  output logic                            timeout_err
);

  localparam int IDX_W = idx_width(NUM_IN);

  // ---------------- state ----------------
  lock_state_e                      r_lock_st [NUM_VCS];
  lock_state_e                      w_lock_st_nxt [NUM_VCS];
  logic [NUM_VCS-1:0][IDX_W-1:0]    r_lock_owner;
  logic [NUM_VCS-1:0][IDX_W-1:0]    w_lock_owner_nxt;
  logic [IDX_W-1:0]                 r_ptr;

  // ---------------- combinational ----------------
  logic [NUM_VCS-1:0]               w_cred_ok;
  logic [NUM_VCS-1:0]               w_cred_err;
  logic [NUM_VCS-1:0]               w_vc_gnt;
  logic [NUM_VCS-1:0]               w_idle_hit;
  logic [NUM_IN-1:0]                w_elig;
  logic [NUM_IN-1:0]                w_gnt;
  logic                             w_gnt_any;
  logic [IDX_W-1:0]                 w_gnt_idx;
  logic [VC_W-1:0]                  w_gnt_vc;
  logic                             w_gnt_last;
  flit_t                            w_out_flit;

  // Eligibility: matching the VC by loop keeps out-of-range in_vc values from
  // ever matching (and from indexing past the per-VC arrays).
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (in_valid[i] && (in_vc[i] == VC_W'(v)) && w_cred_ok[v] &&
            ((r_lock_st[v] == LK_FREE) || (r_lock_owner[v] == IDX_W'(i))))
          w_elig[i] = 1'b1;
      end
    end
  end

  // Round-robin: first eligible input at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!w_gnt_any && w_elig[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDX_W'(idx);
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign in_pop     = w_gnt;
  assign w_gnt_vc   = in_vc[w_gnt_idx];
  assign w_gnt_last = in_last[w_gnt_idx];

  always_comb begin
    w_vc_gnt = '0;
    for (int v = 0; v < NUM_VCS; v++)
      w_vc_gnt[v] = w_gnt_any && (w_gnt_vc == VC_W'(v));
  end

  // ---------------- credit counters ----------------
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    outport_credit_counter #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .CRED_W      (CRED_W)
    ) u_cred (
      .clk     (clk),
      .rst     (rst),
      .i_dec   (w_vc_gnt[v]),
      .i_inc   (credit_return[v]),
      .o_count (credits[v]),
      .o_avail (w_cred_ok[v]),
      .o_err   (w_cred_err[v])
    );
  end

  assign credit_err = |w_cred_err;

  // ---------------- lock timeout (optional) ----------------
`ifdef OUTSTAGE_LOCK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

  logic [NUM_VCS-1:0][IDLE_W-1:0] r_idle;
  logic                           r_timeout_err;

  // A locked VC can only be granted to its owner, so any grant on the VC
  // counts as owner activity. Release fires at the end of the
  // LOCK_TIMEOUT-th consecutive idle cycle.
  always_comb begin
    w_idle_hit = '0;
    for (int v = 0; v < NUM_VCS; v++)
      w_idle_hit[v] = (r_lock_st[v] == LK_LOCKED) && !w_vc_gnt[v] &&
                      (r_idle[v] == IDLE_W'(LOCK_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if ((r_lock_st[v] == LK_LOCKED) && !w_vc_gnt[v] && !w_idle_hit[v])
          r_idle[v] <= r_idle[v] + IDLE_W'(1);
        else
          r_idle[v] <= '0;
      end
      if (|w_idle_hit) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_idle_hit  = '0;
  assign timeout_err = 1'b0;
`endif

  // ---------------- lock FSMs ----------------
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      w_lock_st_nxt[v]    = r_lock_st[v];
      w_lock_owner_nxt[v] = r_lock_owner[v];
      case (r_lock_st[v])
        LK_FREE: begin
          // Single-flit packets (head = tail) never take the lock.
          if (w_vc_gnt[v] && !w_gnt_last) begin
            w_lock_st_nxt[v]    = LK_LOCKED;
            w_lock_owner_nxt[v] = w_gnt_idx;
          end
        end
        LK_LOCKED: begin
          if ((w_vc_gnt[v] && w_gnt_last) || w_idle_hit[v])
            w_lock_st_nxt[v] = LK_FREE;
        end
        default: w_lock_st_nxt[v] = LK_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) r_lock_st[v] <= LK_FREE;
      r_lock_owner <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) r_lock_st[v] <= w_lock_st_nxt[v];
      r_lock_owner <= w_lock_owner_nxt;
    end
  end

  // ---------------- RR pointer and output register ----------------
  always_comb begin
    w_out_flit    = in_flit[w_gnt_idx];
    w_out_flit.vc = vc_id_t'(w_gnt_vc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else begin
      out_valid <= w_gnt_any;
      if (w_gnt_any) begin
        out_flit <= w_out_flit;
        r_ptr    <= (w_gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_outport_stage.sv
module tb_switch_outport_stage;
  import chiplet_types_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid;
  flit_t [3:0]       in_flit;
  logic [3:0][0:0]   in_vc;
  logic [3:0]        in_last;
  logic [3:0]        in_pop;
  logic [1:0]        credit_return;
  logic              out_valid;
  flit_t             out_flit;
  logic [1:0][2:0]   credits;
  logic              credit_err;
  logic              timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  switch_outport_stage #(
    .NUM_IN       (4),
    .NUM_VCS      (2),
    .BUFFER_SIZE  (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_flit       (in_flit),
    .in_vc         (in_vc),
    .in_last       (in_last),
    .in_pop        (in_pop),
    .credit_return (credit_return),
    .out_valid     (out_valid),
    .out_flit      (out_flit),
    .credits       (credits),
    .credit_err    (credit_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk_flit(input int src, input int n);
    flit_t f;
    f      = '0;
    f.head = (n == 0);
    f.data = 32'(src * 256 + n);
    return f;
  endfunction

  task automatic idle_inputs();
    in_valid      = '0;
    in_flit       = '0;
    in_vc         = '0;
    in_last       = '0;
    credit_return = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (credits[0] !== 3'd4) $display("FAIL reset_cred0: got %0d want 4", credits[0]); else n_pass++;
    n_checks++; if (credits[1] !== 3'd4) $display("FAIL reset_cred1: got %0d want 4", credits[1]); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_flit !== '0) $display("FAIL reset_out_flit: got %h want 0", out_flit); else n_pass++;
    n_checks++; if (credit_err !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL reset_errs: got %b%b want 00", credit_err, timeout_err); else n_pass++;
    n_checks++; if (in_pop !== 4'b0000) $display("FAIL reset_pop: got %b want 0000", in_pop); else n_pass++;
  endtask

  task automatic test_single_flit();
    in_valid[2] = 1'b1; in_vc[2] = 1'b1; in_last[2] = 1'b1; in_flit[2] = mk_flit(2, 0);
    #1;
    n_checks++; if (in_pop !== 4'b0100) $display("FAIL single_pop: got %b want 0100", in_pop); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_flit.data !== 32'h200) $display("FAIL single_data: got %h want 00000200", out_flit.data); else n_pass++;
    n_checks++; if (out_flit.vc !== vc_id_t'(1)) $display("FAIL single_vc: got %0d want 1", out_flit.vc); else n_pass++;
    n_checks++; if (credits[1] !== 3'd3) $display("FAIL single_cred1: got %0d want 3", credits[1]); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_wormhole();
    int rem0, rem1;
    logic [3:0] exp_pop;
    do_reset();
    rem0 = 3; rem1 = 3;
    for (int c = 0; c < 6; c++) begin
      in_valid[0] = (rem0 > 0); in_vc[0] = 1'b0; in_last[0] = (rem0 == 1); in_flit[0] = mk_flit(0, 3 - rem0);
      in_valid[1] = (rem1 > 0); in_vc[1] = 1'b0; in_last[1] = (rem1 == 1); in_flit[1] = mk_flit(1, 3 - rem1);
      credit_return[0] = 1'b1;
      #1;
      exp_pop = (c < 3) ? 4'b0001 : 4'b0010;
      n_checks++; if (in_pop !== exp_pop) $display("FAIL wormhole_pop[%0d]: got %b want %b", c, in_pop, exp_pop); else n_pass++;
      tick();
      if (c < 3) rem0--; else rem1--;
    end
    idle_inputs();
    n_checks++; if (out_flit.data !== 32'h102) $display("FAIL wormhole_last_data: got %h want 00000102", out_flit.data); else n_pass++;
    n_checks++; if (credits[0] !== 3'd4) $display("FAIL wormhole_cred0: got %0d want 4", credits[0]); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL wormhole_cerr: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [3:0] exp_pop;
    do_reset();
    in_valid = 4'b0011;
    in_vc[0] = 1'b0; in_last[0] = 1'b1; in_flit[0] = mk_flit(0, 0);
    in_vc[1] = 1'b1; in_last[1] = 1'b1; in_flit[1] = mk_flit(1, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_pop = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      n_checks++; if (in_pop !== exp_pop) $display("FAIL alt_pop[%0d]: got %b want %b", c, in_pop, exp_pop); else n_pass++;
      tick();
    end
    idle_inputs();
    n_checks++; if (credits[0] !== 3'd2 || credits[1] !== 3'd2)
      $display("FAIL alt_credits: got %0d,%0d want 2,2", credits[0], credits[1]); else n_pass++;
    n_checks++; if (out_flit.vc !== vc_id_t'(1)) $display("FAIL alt_last_vc: got %0d want 1", out_flit.vc); else n_pass++;
  endtask

  task automatic test_credit_block();
    do_reset();
    in_valid[2] = 1'b1; in_vc[2] = 1'b0; in_last[2] = 1'b1; in_flit[2] = mk_flit(2, 5);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (in_pop !== 4'b0100) $display("FAIL cred_send_pop[%0d]: got %b want 0100", c, in_pop); else n_pass++;
      tick();
    end
    n_checks++; if (credits[0] !== 3'd0) $display("FAIL cred_empty: got %0d want 0", credits[0]); else n_pass++;
    #1;
    n_checks++; if (in_pop !== 4'b0000) $display("FAIL cred_blocked_pop: got %b want 0000", in_pop); else n_pass++;
    credit_return[0] = 1'b1;
    tick();
    credit_return[0] = 1'b0;
    n_checks++; if (credits[0] !== 3'd1) $display("FAIL cred_returned: got %0d want 1", credits[0]); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL cred_blocked_valid: got %b want 0", out_valid); else n_pass++;
    #1;
    n_checks++; if (in_pop !== 4'b0100) $display("FAIL cred_resume_pop: got %b want 0100", in_pop); else n_pass++;
    credit_return[0] = 1'b1;   // send and return together
    tick();
    idle_inputs();
    n_checks++; if (credits[0] !== 3'd1) $display("FAIL cred_same_cycle: got %0d want 1", credits[0]); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL cred_resume_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL cred_no_err: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_credit_err();
    do_reset();
    credit_return[1] = 1'b1;
    tick();
    credit_return[1] = 1'b0;
    n_checks++; if (credits[1] !== 3'd4) $display("FAIL cerr_count: got %0d want 4", credits[1]); else n_pass++;
    n_checks++; if (credit_err !== 1'b1) $display("FAIL cerr_set: got %b want 1", credit_err); else n_pass++;
    tick(); tick();
    n_checks++; if (credit_err !== 1'b1) $display("FAIL cerr_sticky: got %b want 1", credit_err); else n_pass++;
    do_reset();
    n_checks++; if (credit_err !== 1'b0) $display("FAIL cerr_cleared: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    in_valid[0] = 1'b1; in_vc[0] = 1'b0; in_last[0] = 1'b0; in_flit[0] = mk_flit(0, 0);
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_checks++; if (credits[0] !== 3'd4 || out_valid !== 1'b0)
      $display("FAIL midrst_async: got cred %0d valid %b want 4 0", credits[0], out_valid); else n_pass++;
    tick();
    rst = 1'b0;
    in_valid[1] = 1'b1; in_vc[1] = 1'b0; in_last[1] = 1'b1; in_flit[1] = mk_flit(1, 0);
    #1;
    n_checks++; if (in_pop !== 4'b0010) $display("FAIL midrst_lock_dropped: got %b want 0010", in_pop); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_timeout();
    int bad_pops;
    do_reset();
    in_valid[3] = 1'b1; in_vc[3] = 1'b1; in_last[3] = 1'b0; in_flit[3] = mk_flit(3, 0);
    #1;
    n_checks++; if (in_pop !== 4'b1000) $display("FAIL to_head_pop: got %b want 1000", in_pop); else n_pass++;
    tick();
    idle_inputs();
    in_valid[0] = 1'b1; in_vc[0] = 1'b1; in_last[0] = 1'b1; in_flit[0] = mk_flit(0, 7);
    bad_pops = 0;
`ifdef OUTSTAGE_LOCK_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      #1;
      if (in_pop !== 4'b0000) bad_pops++;
      if (c == 15) begin
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_early_err: got %b want 0", timeout_err); else n_pass++;
      end
      tick();
    end
    n_checks++; if (bad_pops !== 0) $display("FAIL to_locked_pops: got %0d want 0", bad_pops); else n_pass++;
    #1;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err_set: got %b want 1", timeout_err); else n_pass++;
    n_checks++; if (in_pop !== 4'b0001) $display("FAIL to_release_pop: got %b want 0001", in_pop); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (credits[1] !== 3'd2) $display("FAIL to_credits: got %0d want 2", credits[1]); else n_pass++;
`else
    for (int c = 0; c < 24; c++) begin
      #1;
      if (in_pop !== 4'b0000) bad_pops++;
      tick();
    end
    idle_inputs();
    n_checks++; if (bad_pops !== 0) $display("FAIL lock_persist_pops: got %0d want 0", bad_pops); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL lock_persist_err: got %b want 0", timeout_err); else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_flit();
    test_wormhole();
    test_alternate();
    test_credit_block();
    test_credit_err();
    test_reset_midpacket();
    test_lock_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_outport_stage.md
# switch_outport_stage

Parametrised output-port stage for the chiplet switch. It generalises the fixed two-VC crossbar output path to `NUM_VCS` virtual channels with per-VC credit counters and per-VC wormhole locks. It performs round-robin arbitration among `NUM_IN` input buffers and emits one registered flit per cycle toward the link. One instance sits behind each switch outport, after switch allocation.

## Interface
Parameters:
- `NUM_IN`, 8: input buffers competing for this outport.
- `NUM_VCS`, 2: downstream virtual channels; must be ≥1.
- `BUFFER_SIZE`, 8: downstream flit capacity per VC, which is the initial credit count.
- `LOCK_TIMEOUT`, 256: idle-owner cycles before a forced lock release. Used only with `OUTSTAGE_LOCK_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, NUM_IN: buffer i holds a flit for this port.
- `in_flit`, input, NUM_IN × flit_t: head-of-buffer flit.
- `in_vc`, input, NUM_IN × VC_W: output VC assigned by VC allocation.
- `in_last`, input, NUM_IN: flit is the packet tail. A single-flit packet has head=tail.
- `in_pop`, output, NUM_IN: one-hot, combinational. Buffer i's flit is consumed this cycle.
- `credit_return`, input, NUM_VCS: downstream freed one slot on VC v.
- `out_valid`, output, 1: registered flit valid.
- `out_flit`, output, flit_t: registered flit. Its `vc` field is replaced by `in_vc`.
- `credits`, output, NUM_VCS × CRED_W: current credit count per VC.
- `credit_err`, output, 1: sticky. Set when a credit return arrives at a full counter.
- `timeout_err`, output, 1: sticky. Set on forced release. Tied 0 without the macro.

## Operation
- Per-VC lock FSM has two states: FREE and LOCKED(owner).
  - FREE → LOCKED(i) when input i is granted a non-tail flit on VC v.
  - LOCKED(i) → FREE when i is granted with `in_last`.
  - A single-flit packet never leaves FREE.
- Input i is eligible when all of the following hold:
  - `in_valid[i]` is set.
  - Lock[in_vc[i]] is FREE or owned by i.
  - `credits[in_vc[i]] > 0`.
- Arbitration: round-robin over eligible inputs. The search starts at the pointer (reset 0). After a grant, the pointer moves to grant+1 mod NUM_IN. With no grant, the pointer holds.
- Exactly one grant at most per cycle. `in_pop` equals the grant vector.
- Credits: a grant on VC v decrements the counter; `credit_return[v]` increments it.
  - If both happen in the same cycle, the counter is unchanged.
  - A return at `BUFFER_SIZE` with no send leaves the counter unchanged and sets `credit_err`.
  - A counter at 0 blocks VC v.
- Output register loads the granted flit with `vc` = `in_vc`. `out_valid` = 1 on a grant, else 0. `out_flit` holds its last value when idle.
- Widths: VC_W = max(1, $clog2(NUM_VCS)); CRED_W = $clog2(BUFFER_SIZE+1).
- Inputs with `in_vc` ≥ NUM_VCS are never eligible.

## Timing
- Reset values:
  - `out_valid` = 0, `out_flit` = '0.
  - `credits` = BUFFER_SIZE for every VC.
  - All locks FREE, RR pointer 0.
  - `credit_err` = 0, `timeout_err` = 0.
- Reset asserted mid-packet drops all locks immediately. Upstream is also reset.
- `in_pop[i]` depends combinationally on inputs and the current state, in the same cycle as `in_valid`.
- `out_valid` and `out_flit` follow 1 cycle after the grant. Throughput is 1 flit per cycle.
- Credit decrement is visible on `credits` in the cycle after the grant. A return is visible the cycle after `credit_return`. A credit returned in cycle t is usable for a grant in t+1.
- A lock acquired in cycle t constrains eligibility from t+1. A release in cycle t frees the VC for other inputs in t+1.

## Configuration
- Macro: `OUTSTAGE_LOCK_TIMEOUT_EN`.
- Defined:
  - Each VC has an idle counter. It clears on any grant to the lock owner or while FREE, and increments while LOCKED and the owner is not granted.
  - On reaching `LOCK_TIMEOUT`, the lock goes FREE next cycle and `timeout_err` is set (sticky).
  - Credits are untouched.
- Undefined: no counters, and locks persist indefinitely. `timeout_err` = 0.

## Structure
- `chiplet_types_pkg`: add `OUTSTAGE_MAX_VCS` and a `vc_id_t` typedef. Reuse `flit_t`.
- Sub-module `outport_credit_counter`: one instance per VC. Implements saturating up/down count, the block flag, and the error flag.
- Round-robin arbitration is inline.

## Test plan
- Reset with NUM_IN=4, NUM_VCS=2, BUFFER_SIZE=4. Check `credits` = {4,4} and `out_valid` = 0. Then send one single-flit packet on input 2, VC1 → `in_pop` = 0100 same cycle, `out_valid` next cycle, `credits[1]` = 3.
- Inputs 0 and 1 each start 3-flit packets on VC0 simultaneously → input 0's three flits are contiguous, then input 1's. No interleave on VC0.
- Inputs 0 (VC0) and 1 (VC1) valid, all single-flit packets → grants alternate 0,1,0,1.
- Send 4 flits on VC0 with no returns → 5th request blocked with `credits[0]` = 0. Pulse `credit_return[0]` → grant next cycle. A simultaneous send and return keeps the count at 1.
- Pulse `credit_return[1]` at credits = 4 → count stays 4, `credit_err` = 1 until reset.
- With macro and LOCK_TIMEOUT=16: input 3 sends a head flit on VC1, then drops `in_valid` → after 16 cycles VC1 is FREE, `timeout_err` = 1, and input 0 is then granted on VC1.
